roomavail_calc_mc: RTL and testbench

Multi-channel successor to the single-channel data-FIFO room tracker. It keeps one free-space ("room") counter per DMA channel FIFO. Each counter is decremented on push reservations and incremented on pop releases. Results saturate at 0 and at FIFO_DEPTH, and sticky error flags record any clamp. The block sits between the per-channel write-request arbiter and the FIFO read side, and feeds room, low-water and full status to the DMA channel schedulers.

---
 rtl/roomavail_calc_mc_if.sv | 30 +++
 rtl/roomavail_calc_mc.sv | 98 +++++++++
 tb/tb_roomavail_calc_mc.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/roomavail_calc_mc_if.sv
// Channel-scheduler bus for roomavail_calc_mc: per-channel reserve/release strobes in,
// registered room and status flags out. Master drives strobes, slave is the tracker.
interface roomavail_calc_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned VAL_W  = 8
);
  logic [NUM_CH-1:0]       subtract_room;
  logic [NUM_CH*VAL_W-1:0] subtract_value;
  logic [NUM_CH-1:0]       add_room;
  logic [NUM_CH*VAL_W-1:0] add_value;
  logic [NUM_CH-1:0]       flush;
  logic [NUM_CH-1:0]       err_clr;
  logic [NUM_CH*CNT_W-1:0] datafifo_room;
  logic [NUM_CH-1:0]       room_low;
  logic [NUM_CH-1:0]       room_full;
  logic [NUM_CH-1:0]       underflow_err;
  logic [NUM_CH-1:0]       overflow_err;
  logic [NUM_CH*CNT_W-1:0] min_room;

  modport master (
    output subtract_room, subtract_value, add_room, add_value, flush, err_clr,
    input  datafifo_room, room_low, room_full, underflow_err, overflow_err, min_room
  );

  modport slave (
    input  subtract_room, subtract_value, add_room, add_value, flush, err_clr,
    output datafifo_room, room_low, room_full, underflow_err, overflow_err, min_room
  );
endinterface

// File: rtl/roomavail_calc_mc.sv
// Per-channel saturating FIFO free-space tracker with sticky clamp flags.
// Define ROOMAVAIL_MIN_WATERMARK_EN to build the per-channel min_room low watermark.
module roomavail_calc_mc #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 128,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned VAL_W      = 8,
  parameter int unsigned LOW_THRESH = 16
) (
  input logic                clk,
  input logic                rst,
  roomavail_calc_mc_if.slave bus
);
  localparam int unsigned SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] Depth  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LowThr = CNT_W'(LOW_THRESH);
  localparam logic signed [SW-1:0] DepthS = SW'(FIFO_DEPTH);
  localparam logic LowRst = (FIFO_DEPTH < LOW_THRESH);

  logic [NUM_CH-1:0][CNT_W-1:0] room_q, room_d;
  logic [NUM_CH-1:0]            low_q, low_d, full_q, full_d;
  logic [NUM_CH-1:0]            uf_q, uf_d, of_q, of_d;
  logic [NUM_CH-1:0][SW-1:0]    sub_amt, add_amt, nxt;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sub_amt[i] = bus.subtract_room[i] ? SW'(bus.subtract_value[i*VAL_W +: VAL_W]) : '0;
      add_amt[i] = bus.add_room[i] ? SW'(bus.add_value[i*VAL_W +: VAL_W]) : '0;
      // Wrap-around arithmetic in SW bits is exact for the full room +/- value range.
      nxt[i]     = SW'(room_q[i]) - sub_amt[i] + add_amt[i];
      room_d[i]  = room_q[i];
      uf_d[i]    = uf_q[i] & ~bus.err_clr[i];
      of_d[i]    = of_q[i] & ~bus.err_clr[i];
      if (bus.flush[i]) begin
        room_d[i] = Depth;
      end else if (bus.subtract_room[i] || bus.add_room[i]) begin
        if (nxt[i][SW-1]) begin
          room_d[i] = '0;
          uf_d[i]   = 1'b1;
        end else if ($signed(nxt[i]) > DepthS) begin
          room_d[i] = Depth;
          of_d[i]   = 1'b1;
        end else begin
          room_d[i] = nxt[i][CNT_W-1:0];
        end
      end
      low_d[i]  = room_d[i] < LowThr;
      full_d[i] = room_d[i] == Depth;
    end
  end

`ifdef ROOMAVAIL_MIN_WATERMARK_EN
  logic [NUM_CH-1:0][CNT_W-1:0] min_q, min_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.flush[i]) begin
        min_d[i] = Depth;
      end else begin
        min_d[i] = (room_d[i] < min_q[i]) ? room_d[i] : min_q[i];
      end
    end
  end

  assign bus.min_room = min_q;
`else
  assign bus.min_room = {NUM_CH{Depth}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      room_q <= {NUM_CH{Depth}};
      low_q  <= {NUM_CH{LowRst}};
      full_q <= '1;
      uf_q   <= '0;
      of_q   <= '0;
`ifdef ROOMAVAIL_MIN_WATERMARK_EN
      min_q  <= {NUM_CH{Depth}};
`endif
    end else begin
      room_q <= room_d;
      low_q  <= low_d;
      full_q <= full_d;
      uf_q   <= uf_d;
      of_q   <= of_d;
`ifdef ROOMAVAIL_MIN_WATERMARK_EN
      min_q  <= min_d;
`endif
    end
  end

  assign bus.datafifo_room = room_q;
  assign bus.room_low      = low_q;
  assign bus.room_full     = full_q;
  assign bus.underflow_err = uf_q;
  assign bus.overflow_err  = of_q;

endmodule

// File: tb/tb_roomavail_calc_mc.sv
// Bench for roomavail_calc_mc: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an integer reference model.
`timescale 1ns/1ps
module tb_roomavail_calc_mc;
  localparam int NCH = 4;
  localparam int DEPTH = 128;
  localparam int CW = 8;
  localparam int VW = 8;
  localparam int LOWT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  roomavail_calc_mc_if #(.NUM_CH(NCH), .CNT_W(CW), .VAL_W(VW)) bus ();

  roomavail_calc_mc #(
    .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .CNT_W(CW), .VAL_W(VW), .LOW_THRESH(LOWT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int m_room[NCH];
  int m_min[NCH];
  bit m_uf[NCH];
  bit m_of[NCH];
  bit m_valid = 1'b0;
  int n_tmp;
  logic [31:0] e_room, e_min;
  logic [3:0]  e_low, e_full, e_uf, e_of;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer room per channel, clamped, with sticky flags.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_room[i] = DEPTH;
        m_min[i]  = DEPTH;
        m_uf[i]   = 1'b0;
        m_of[i]   = 1'b0;
      end else begin
        if (bus.err_clr[i]) begin
          m_uf[i] = 1'b0;
          m_of[i] = 1'b0;
        end
        if (bus.flush[i]) begin
          m_room[i] = DEPTH;
          m_min[i]  = DEPTH;
        end else begin
          n_tmp = m_room[i];
          if (bus.subtract_room[i]) n_tmp = n_tmp - int'(bus.subtract_value[i*VW +: VW]);
          if (bus.add_room[i]) n_tmp = n_tmp + int'(bus.add_value[i*VW +: VW]);
          if (n_tmp < 0) begin
            n_tmp   = 0;
            m_uf[i] = 1'b1;
          end else if (n_tmp > DEPTH) begin
            n_tmp   = DEPTH;
            m_of[i] = 1'b1;
          end
          m_room[i] = n_tmp;
          if (n_tmp < m_min[i]) m_min[i] = n_tmp;
        end
      end
    end
    if (rst) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      for (int i = 0; i < NCH; i++) begin
        e_room[i*CW +: CW] = CW'(m_room[i]);
`ifdef ROOMAVAIL_MIN_WATERMARK_EN
        e_min[i*CW +: CW]  = CW'(m_min[i]);
`else
        e_min[i*CW +: CW]  = CW'(DEPTH);
`endif
        e_low[i]  = m_room[i] < LOWT;
        e_full[i] = m_room[i] == DEPTH;
        e_uf[i]   = m_uf[i];
        e_of[i]   = m_of[i];
      end
      chk("model_room", bus.datafifo_room, e_room);
      chk("model_low", 32'(bus.room_low), 32'(e_low));
      chk("model_full", 32'(bus.room_full), 32'(e_full));
      chk("model_uf", 32'(bus.underflow_err), 32'(e_uf));
      chk("model_of", 32'(bus.overflow_err), 32'(e_of));
      chk("model_min", bus.min_room, e_min);
    end
  end

  task automatic clear();
    bus.subtract_room  = '0;
    bus.subtract_value = '0;
    bus.add_room       = '0;
    bus.add_value      = '0;
    bus.flush          = '0;
    bus.err_clr        = '0;
  endtask

  task automatic sub(input int ch, input int v);
    bus.subtract_room[ch]          = 1'b1;
    bus.subtract_value[ch*VW +: VW] = VW'(v);
  endtask

  task automatic add(input int ch, input int v);
    bus.add_room[ch]           = 1'b1;
    bus.add_value[ch*VW +: VW] = VW'(v);
  endtask

  task automatic tick();
    @(negedge clk);
    clear();
  endtask

  function automatic logic [31:0] room(input int ch);
    return 32'(bus.datafifo_room[ch*CW +: CW]);
  endfunction

  initial begin
    clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_room", bus.datafifo_room, 32'h8080_8080);
    chk("rst_full", 32'(bus.room_full), 32'hF);
    chk("rst_low", 32'(bus.room_low), 32'h0);
    chk("rst_uf", 32'(bus.underflow_err), 32'h0);
    chk("rst_of", 32'(bus.overflow_err), 32'h0);
    chk("rst_min", bus.min_room, 32'h8080_8080);

    sub(0, 100); tick();
    chk("c0_sub100", room(0), 28);
    sub(0, 20); tick();
    chk("c0_sub20", room(0), 8);
    chk("c0_low", 32'(bus.room_low[0]), 1);
    add(0, 120); tick();
    chk("c0_add120", room(0), 128);
    chk("c0_full", 32'(bus.room_full[0]), 1);
    chk("c123_idle", 32'(bus.datafifo_room[31:8]), 32'h80_8080);

    sub(2, 118); tick();
    chk("c2_to10", room(2), 10);
    sub(2, 30); tick();
    chk("c2_uf_room", room(2), 0);
    chk("c2_uf_set", 32'(bus.underflow_err[2]), 1);
    bus.err_clr[2] = 1'b1; tick();
    chk("c2_uf_clr", 32'(bus.underflow_err[2]), 0);
    sub(2, 1); bus.err_clr[2] = 1'b1; tick();
    chk("c2_set_wins", 32'(bus.underflow_err[2]), 1);

    sub(1, 8); tick();
    chk("c1_to120", room(1), 120);
    sub(1, 50); add(1, 60); tick();
    chk("c1_ovf_room", room(1), 128);
    chk("c1_ovf_set", 32'(bus.overflow_err[1]), 1);
    sub(1, 64); tick();
    sub(1, 40); add(1, 40); tick();
    chk("c1_net0", room(1), 64);

    sub(3, 123); tick();
    chk("c3_to5", room(3), 5);
    bus.flush[3] = 1'b1; sub(3, 10); tick();
    chk("c3_flush", room(3), 128);
    chk("c3_no_uf", 32'(bus.underflow_err[3]), 0);
    add(3, 5); sub(0, 7); rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_room", bus.datafifo_room, 32'h8080_8080);
    chk("mid_rst_err", 32'({bus.underflow_err, bus.overflow_err}), 0);

    sub(0, 88); tick();
    add(0, 60); tick();
    sub(0, 80); tick();
    add(0, 108); tick();
    chk("wm_room", room(0), 128);
`ifdef ROOMAVAIL_MIN_WATERMARK_EN
    chk("wm_min", 32'(bus.min_room[7:0]), 20);
`else
    chk("wm_min", 32'(bus.min_room[7:0]), 128);
`endif
    bus.flush[0] = 1'b1; tick();
    chk("wm_flush", 32'(bus.min_room[7:0]), 128);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 1) == 1)
          sub(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 24));
        if ($urandom_range(0, 1) == 1)
          add(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 24));
        if ($urandom_range(0, 31) == 0) bus.flush[i] = 1'b1;
        if ($urandom_range(0, 15) == 0) bus.err_clr[i] = 1'b1;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
